// File: rtl/mem_block_engine.sv
// rtl/mem_block_engine.sv - fill/copy/sum block sequencer driving a pointer-protocol byte memory
module mem_block_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_Start,
  input  logic [1:0]        i_Op,
  input  logic [ADDR_W-1:0] i_SrcAddr,
  input  logic [ADDR_W-1:0] i_DstAddr,
  input  logic [ADDR_W:0]   i_Length,
  input  logic [DATA_W-1:0] i_FillData,
  input  logic [DATA_W-1:0] i_MemReadData,
  output logic [ADDR_W-1:0] o_MemAddress,
  output logic [DATA_W-1:0] o_MemWriteData,
  output logic              o_MemWriteEn,
  output logic              o_MemReadEn,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error,
  output logic [DATA_W-1:0] o_Checksum
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PTR  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RPTR = 3'd3;
  localparam logic [2:0] S_RCAP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] checksum_q;
  logic              err_q;

  logic cmd_bad;
  logic last_byte;

  assign cmd_bad   = (i_Length == '0) || (i_Length > MAX_LEN) || (i_Op == 2'b11);
  assign last_byte = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_Start) begin
            op_q       <= i_Op;
            src_q      <= i_SrcAddr;
            dst_q      <= i_DstAddr;
            len_q      <= i_Length;
            data_q     <= i_FillData;
            idx_q      <= '0;
            checksum_q <= '0;
            err_q      <= cmd_bad;
            if (cmd_bad)               state_q <= S_DONE;
            else if (i_Op == OP_FILL)  state_q <= S_PTR;
            else                       state_q <= S_RPTR;
          end
        end
        S_RPTR: state_q <= (op_q == OP_COPY) ? S_PTR : S_RCAP;
        S_PTR: begin
          // copy: read data reflects the source pointer latched in RPTR
          if (op_q == OP_COPY) begin
            data_q     <= i_MemReadData;
            checksum_q <= checksum_q + i_MemReadData;
          end
          state_q <= S_WR;
        end
        S_WR: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (last_byte)             state_q <= S_DONE;
          else if (op_q == OP_COPY)  state_q <= S_RPTR;
          else                       state_q <= S_PTR;
        end
        S_RCAP: begin
          checksum_q <= checksum_q + i_MemReadData;
          idx_q      <= idx_q + ADDR_W'(1);
          state_q    <= last_byte ? S_DONE : S_RPTR;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_MemAddress   = '0;
    o_MemWriteData = '0;
    o_MemWriteEn   = 1'b0;
    o_MemReadEn    = 1'b0;
    case (state_q)
      S_PTR: begin
        o_MemReadEn  = 1'b1;
        o_MemAddress = dst_q + idx_q;
      end
      S_WR: begin
        // both enables high: memory commits to the pointer latched in PTR
        o_MemReadEn    = 1'b1;
        o_MemWriteEn   = 1'b1;
        o_MemAddress   = dst_q + idx_q;
        o_MemWriteData = data_q;
      end
      S_RPTR, S_RCAP: begin
        o_MemReadEn  = 1'b1;
        o_MemAddress = src_q + idx_q;
      end
      default: ;
    endcase
  end

  assign o_Busy     = (state_q == S_PTR) || (state_q == S_WR) ||
                      (state_q == S_RPTR) || (state_q == S_RCAP);
  assign o_Done     = (state_q == S_DONE);
  assign o_Error    = (state_q == S_DONE) && err_q;
  assign o_Checksum = checksum_q;

endmodule

// File: tb/tb_mem_block_engine.sv
// tb/tb_mem_block_engine.sv - scoreboard bench for mem_block_engine with a pointer-protocol memory model
module tb_mem_block_engine;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_Start = 1'b0;
  logic [1:0]  i_Op = '0;
  logic [9:0]  i_SrcAddr = '0;
  logic [9:0]  i_DstAddr = '0;
  logic [10:0] i_Length = '0;
  logic [7:0]  i_FillData = '0;
  logic [7:0]  i_MemReadData;
  logic [9:0]  o_MemAddress;
  logic [7:0]  o_MemWriteData;
  logic        o_MemWriteEn;
  logic        o_MemReadEn;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Error;
  logic [7:0]  o_Checksum;

  mem_block_engine #(.ADDR_W(10), .DATA_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_Start(i_Start), .i_Op(i_Op),
    .i_SrcAddr(i_SrcAddr), .i_DstAddr(i_DstAddr), .i_Length(i_Length),
    .i_FillData(i_FillData), .i_MemReadData(i_MemReadData),
    .o_MemAddress(o_MemAddress), .o_MemWriteData(o_MemWriteData),
    .o_MemWriteEn(o_MemWriteEn), .o_MemReadEn(o_MemReadEn),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error), .o_Checksum(o_Checksum)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // memory: pointer latched when exactly one enable is high, write goes to the latched pointer
  logic [7:0] mem [1024];
  logic [7:0] exp_mem [1024];
  logic [9:0] ptr;
  logic       preload = 1'b1;

  always @(posedge i_clk) begin
    if (preload) begin
      for (int k = 0; k < 1024; k++) mem[k] <= k[7:0] ^ 8'h3C;
      ptr <= '0;
    end else begin
      if (o_MemReadEn ^ o_MemWriteEn) ptr <= o_MemAddress;
      if (o_MemReadEn && o_MemWriteEn) mem[ptr] <= o_MemWriteData;
    end
  end
  assign i_MemReadData = mem[ptr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int         t0;
    int         lat;
    logic       err;
    logic [7:0] sum;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [9:0] cur_dst = '0;
  logic       prev_ptr = 1'b0;
  logic [9:0] prev_addr = '0;
  logic       prev_busy = 1'b0;
  int         wr_cnt = 0;

  always @(negedge i_clk) begin
    if (!o_Busy)
      chk("idle_mem_outs", 32'({o_MemAddress, o_MemWriteData, o_MemWriteEn, o_MemReadEn}), 32'd0);
    if (o_Busy && !prev_busy) wr_cnt = 0;
    if (o_MemWriteEn) begin
      chk("we_needs_re", 32'(o_MemReadEn), 32'd1);
      chk("wr_after_ptr", 32'({prev_ptr, prev_addr}), 32'({1'b1, cur_dst + wr_cnt[9:0]}));
      wr_cnt++;
    end
    if (o_Done) begin
      chk("busy_in_done", 32'(o_Busy), 32'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        chk("error_flag", 32'(o_Error), 32'(mon_e.err));
        chk("checksum", 32'(o_Checksum), 32'(mon_e.sum));
      end
    end
    prev_ptr  = o_MemReadEn & ~o_MemWriteEn;
    prev_addr = o_MemAddress;
    prev_busy = o_Busy;
  end

  // lim bounds how many bytes the model commits (for a command cut short by reset)
  task automatic run_cmd(input logic [1:0] op, input logic [9:0] src, input logic [9:0] dst,
                         input logic [10:0] len, input logic [7:0] fill, input int lim = 2048);
    exp_t       e;
    logic [7:0] s;
    logic [9:0] a_s;
    logic [9:0] a_d;
    logic       bad;
    @(negedge i_clk);
    i_Start = 1'b1; i_Op = op; i_SrcAddr = src; i_DstAddr = dst;
    i_Length = len; i_FillData = fill; cur_dst = dst;
    e.t0 = cyc;
    bad = (len == 11'd0) || (len > 11'd1024) || (op == 2'b11);
    s = '0;
    e.lat = 1;
    if (!bad) begin
      for (int k = 0; k < int'(len); k++) begin
        a_s = src + 10'(k);
        a_d = dst + 10'(k);
        if (op == 2'b00) begin
          if (k < lim) exp_mem[a_d] = fill;
        end else if (op == 2'b01) begin
          s = s + exp_mem[a_s];
          if (k < lim) exp_mem[a_d] = exp_mem[a_s];
        end else begin
          s = s + exp_mem[a_s];
        end
      end
      e.lat = (op == 2'b01) ? 3 * int'(len) + 1 : 2 * int'(len) + 1;
    end
    e.err = bad;
    e.sum = s;
    sb.push_back(e);
    @(negedge i_clk);
    i_Start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic mem_compare(input string tag);
    int n = 0;
    for (int k = 0; k < 1024; k++) if (mem[k] !== exp_mem[k]) n++;
    chk(tag, 32'(n), 32'd0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 1024; k++) exp_mem[k] = k[7:0] ^ 8'h3C;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", 32'({o_MemAddress, o_MemWriteData, o_MemWriteEn, o_MemReadEn,
                              o_Busy, o_Done, o_Error, o_Checksum}), 32'd0);
    i_rst_n = 1'b1;
    preload = 1'b0;

    // fill wrapping across 0x3FF -> 0x000
    run_cmd(2'b00, 10'h000, 10'h3FE, 11'd4, 8'hA5);
    wait_idle(100);
    chk("fill_3fe", 32'(mem[10'h3FE]), 32'hA5);
    chk("fill_001", 32'(mem[10'h001]), 32'hA5);
    chk("fill_002_kept", 32'(mem[10'h002]), 32'(8'h02 ^ 8'h3C));
    chk("fill_checksum", 32'(o_Checksum), 32'd0);
    mem_compare("mem_fill");

    run_cmd(2'b00, 10'h000, 10'h010, 11'd1, 8'h01); wait_idle(20);
    run_cmd(2'b00, 10'h000, 10'h011, 11'd1, 8'h02); wait_idle(20);
    run_cmd(2'b00, 10'h000, 10'h012, 11'd1, 8'h03); wait_idle(20);
    run_cmd(2'b01, 10'h010, 10'h100, 11'd3, 8'h00);
    wait_idle(100);
    chk("copy_checksum_held", 32'(o_Checksum), 32'h06);
    chk("copy_102", 32'(mem[10'h102]), 32'h03);
    mem_compare("mem_copy");

    // overlapping forward copy replicates the first source byte
    run_cmd(2'b01, 10'h010, 10'h011, 11'd3, 8'h00);
    wait_idle(100);
    chk("overlap_013", 32'(mem[10'h013]), 32'h01);
    mem_compare("mem_overlap");

    run_cmd(2'b00, 10'h000, 10'h000, 11'd1024, 8'hFF);
    wait_idle(2200);
    run_cmd(2'b10, 10'h000, 10'h000, 11'd1024, 8'h00);
    wait_idle(2200);
    chk("sum_1024_ff", 32'(o_Checksum), 32'h00);
    mem_compare("mem_sum");

    run_cmd(2'b00, 10'h000, 10'h020, 11'd0, 8'h11);    wait_idle(10);
    run_cmd(2'b00, 10'h000, 10'h020, 11'd1025, 8'h11); wait_idle(10);
    run_cmd(2'b11, 10'h000, 10'h020, 11'd4, 8'h11);    wait_idle(10);
    mem_compare("mem_reject");

    // starts while busy and in DONE are dropped
    run_cmd(2'b00, 10'h000, 10'h050, 11'd4, 8'h77);
    i_Start = 1'b1;
    @(negedge i_clk);
    i_Start = 1'b0;
    n = 0;
    while (!o_Done && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("busy_done_seen", 32'(o_Done), 32'd1);
    i_Start = 1'b1;
    @(negedge i_clk);
    i_Start = 1'b0;
    repeat (12) @(negedge i_clk);
    chk("busy_sb_empty", 32'(sb.size()), 32'd0);
    chk("busy_still_idle", 32'(o_Busy), 32'd0);
    mem_compare("mem_busy");

    // reset during byte 2 of a 5-byte copy
    run_cmd(2'b01, 10'h200, 10'h300, 11'd5, 8'h00, 2);
    repeat (6) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({o_MemAddress, o_MemWriteData, o_MemWriteEn, o_MemReadEn,
                                 o_Busy, o_Done, o_Error, o_Checksum}), 32'd0);
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    mem_compare("mem_reset_copy");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
